// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one single-port synchronous SRAM (256x8 by default) between N_REQ
// requesters. One request is accepted per clock, chosen round-robin. The
// accepted request is turned into a registered SRAM command on the next edge;
// read data comes back to the owning requester a fixed two edges after
// acceptance.
//
// Optional build macro:
//   SRAM_ARB_PRIO_EN  - requester 0 gets strict priority over everybody else.
//                       While req_valid[0] is high it wins and the round-robin
//                       pointer does not move; the remaining requesters share
//                       the port round-robin whenever requester 0 is idle.
//                       Undefined (default): pure round-robin.
//
// Ports:
//   clk            in   system clock (single domain)
//   reset          in   asynchronous, active-high reset
//   req_valid      in   [N_REQ]          request valid per requester
//   req_wr         in   [N_REQ]          1 = write, 0 = read
//   req_addr       in   [N_REQ*ADDR_W]   requester k at [k*ADDR_W +: ADDR_W]
//   req_wdata      in   [N_REQ*DATA_W]   requester k at [k*DATA_W +: DATA_W]
//   req_ready      out  [N_REQ]          one-hot grant (combinational)
//   rsp_valid      out  [N_REQ]          one-cycle read-data pulse per requester
//   rsp_data       out  [DATA_W]         read data, meaningful with rsp_valid
//   sram_reset_n   out                   SRAM reset_n (registered ~reset)
//   sram_wr_rd_en  out                   SRAM write enable (0 = read)
//   sram_addr      out  [ADDR_W]         SRAM address
//   sram_data_in   out  [DATA_W]         SRAM write data
//   sram_data_out  in   [DATA_W]         SRAM read data
//   busy           out                   high while any read is in flight
//
// Handshake (valid/ready): a requester raises req_valid[k] and holds its
// wr/addr/wdata stable; the transfer happens at the rising edge where both
// req_valid[k] and req_ready[k] are high. req_ready never depends on anything
// but req_valid, the round-robin pointer and reset, and nothing is latched
// for a requester that drops req_valid before it is granted.
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_wr,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       sram_reset_n,
  output logic                       sram_wr_rd_en,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic [DATA_W-1:0]          sram_data_in,
  input  logic [DATA_W-1:0]          sram_data_out,
  output logic                       busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  rr_ptr_q,        rr_ptr_d;
  logic              sram_reset_n_q;
  logic              sram_wr_rd_en_q, sram_wr_rd_en_d;
  logic [ADDR_W-1:0] sram_addr_q,     sram_addr_d;
  logic [DATA_W-1:0] sram_data_in_q,  sram_data_in_d;

  // Read-tag pipeline: stage 1 tracks the command just issued to the SRAM,
  // stage 2 the command whose data the SRAM is producing this cycle.
  logic              rd_v1_q,         rd_v1_d;
  logic [PTR_W-1:0]  id1_q,           id1_d;
  logic              rd_v2_q,         rd_v2_d;
  logic [PTR_W-1:0]  id2_q,           id2_d;
  logic [N_REQ-1:0]  rsp_valid_q,     rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,      rsp_data_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [PTR_W-1:0]  next_ptr;

  // Two-pass round-robin search: first the requesters at or above rr_ptr,
  // then wrap around to the lowest valid index.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef SRAM_ARB_PRIO_EN
    // Requester 0 pre-empts the search; grant_idx already points at it.
    if (req_valid[0]) begin
      grant_any = 1'b1;
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

  // No grants until the SRAM itself has left reset.
  assign accept = grant_any && !reset && sram_reset_n_q;

  always_comb begin
    grant     = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == grant_idx) begin
        grant[i]  = accept;
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    sram_wr_rd_en_d = 1'b0;          // idle cycles become harmless reads
    sram_addr_d     = sram_addr_q;
    sram_data_in_d  = sram_data_in_q;
    rd_v1_d         = 1'b0;
    id1_d           = id1_q;

    if (accept) begin
      sram_wr_rd_en_d = sel_wr;
      sram_addr_d     = sel_addr;
      sram_data_in_d  = sel_wdata;
      rd_v1_d         = ~sel_wr;
      id1_d           = grant_idx;
`ifdef SRAM_ARB_PRIO_EN
      // Priority grants to requester 0 leave the rotation among the others
      // undisturbed.
      if (grant_idx != '0) begin
        rr_ptr_d = next_ptr;
      end
`else
      rr_ptr_d = next_ptr;
`endif
    end

    rd_v2_d = rd_v1_q;
    id2_d   = id1_q;

    // rsp_data only moves when a response is issued; otherwise it holds.
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (rd_v2_q) begin
      rsp_data_d = sram_data_out;
      for (int i = 0; i < N_REQ; i++) begin
        if (PTR_W'(i) == id2_q) begin
          rsp_valid_d[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      sram_reset_n_q  <= 1'b0;
      sram_wr_rd_en_q <= 1'b0;
      sram_addr_q     <= '0;
      sram_data_in_q  <= '0;
      rd_v1_q         <= 1'b0;
      id1_q           <= '0;
      rd_v2_q         <= 1'b0;
      id2_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      sram_reset_n_q  <= 1'b1;
      sram_wr_rd_en_q <= sram_wr_rd_en_d;
      sram_addr_q     <= sram_addr_d;
      sram_data_in_q  <= sram_data_in_d;
      rd_v1_q         <= rd_v1_d;
      id1_q           <= id1_d;
      rd_v2_q         <= rd_v2_d;
      id2_q           <= id2_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready     = grant;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign sram_reset_n  = sram_reset_n_q;
  assign sram_wr_rd_en = sram_wr_rd_en_q;
  assign sram_addr     = sram_addr_q;
  assign sram_data_in  = sram_data_in_q;
  assign busy          = rd_v1_q | rd_v2_q | (|rsp_valid_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter with two requesters and a behavioural write-first
// 256x8 synchronous SRAM. Requests are applied one per cycle; expected grants
// come from a table (directed part) or a small round-robin model (sequences and
// random part). Every accepted read pushes {due cycle, requester, data} onto
// exp_q, with the data taken from a reference memory; responses are popped and
// compared on the falling edge of the cycle they are due.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int QW = 16 + N + DW;

`ifdef SRAM_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk       = 1'b0;
  logic              reset     = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_wr    = '0;
  logic [N*AW-1:0]   req_addr  = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              sram_reset_n;
  logic              sram_wr_rd_en;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_data_in;
  logic [DW-1:0]     sram_data_out;
  logic              busy;

  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .sram_reset_n  (sram_reset_n),
    .sram_wr_rd_en (sram_wr_rd_en),
    .sram_addr     (sram_addr),
    .sram_data_in  (sram_data_in),
    .sram_data_out (sram_data_out),
    .busy          (busy)
  );

  // Write-first synchronous SRAM; reset clears only the output register.
  logic [DW-1:0] sram_mem [256];
  always @(posedge clk or negedge sram_reset_n) begin
    if (!sram_reset_n) begin
      sram_data_out <= '0;
    end else if (sram_wr_rd_en) begin
      sram_mem[sram_addr] <= sram_data_in;
      sram_data_out       <= sram_data_in;
    end else begin
      sram_data_out <= sram_mem[sram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference state
  // ---------------------------------------------------------------------------
  int            n_vec  = 0;
  int            n_fail = 0;
  logic [QW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [256];
  int            model_ptr = 0;
  logic [2:0]    hist      = '0;   // read accepted at E, E-1, E-2
  logic          exp_we    = 1'b0;
  logic [AW-1:0] exp_addr  = '0;
  logic [DW-1:0] exp_din   = '0;
  logic [DW-1:0] last_rsp  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected grant: first valid at or after ptr (mod N); with priority enabled,
  // requester 0 wins outright whenever it is valid.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] r;
    r = '0;
    if (PRIO && v[0]) begin
      r[0] = 1'b1;
      return r;
    end
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr + i) % N;
      if (v[j]) begin
        r[j] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Advance to the falling edge and compare any response due this cycle.
  task automatic tick();
    logic [QW-1:0] e;
    @(negedge clk);
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0][QW-1 -: 16] == cyc) begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e[DW +: N]));
        chk("rsp_data",  32'(rsp_data),  32'(e[DW-1:0]));
        last_rsp = e[DW-1:0];
      end else if (rsp_valid != '0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end
    end
  endtask

  // Drive one cycle of requests, check the grant, predict the SRAM command,
  // busy and (via exp_q) the response.
  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] wr,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                       input logic [N-1:0] er);
    logic          acc;
    int            k;
    logic [AW-1:0] ak;
    logic [DW-1:0] dk;
    tick();
    req_valid = v;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    #1;
    chk("req_ready", 32'(req_ready), 32'(er));
    acc = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      if (er[i]) begin
        acc = 1'b1;
        k   = i;
      end
    end
    if (acc) begin
      ak = a[k*AW +: AW];
      dk = d[k*DW +: DW];
      if (wr[k]) ref_mem[ak] = dk;
      else       exp_q.push_back({cyc + 16'd3, er, ref_mem[ak]});
      exp_we   = wr[k];
      exp_addr = ak;
      exp_din  = dk;
      if (!(PRIO && k == 0)) model_ptr = (k + 1) % N;
    end else begin
      exp_we = 1'b0;
    end
    hist = {hist[1:0], acc && !wr[k]};
    @(posedge clk);
    #1;
    chk("sram_wr_rd_en", 32'(sram_wr_rd_en), 32'(exp_we));
    chk("sram_addr",     32'(sram_addr),     32'(exp_addr));
    chk("sram_data_in",  32'(sram_data_in),  32'(exp_din));
    chk("busy",          32'(busy),          32'(|hist));
  endtask

  task automatic apply_rr(input logic [N-1:0] v, input logic [N-1:0] wr,
                          input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    apply(v, wr, a, d, rr_pick(v, model_ptr));
  endtask

  // Assert reset (with both requesters valid to show grants are blocked),
  // hold n cycles, release mid-cycle, and follow sram_reset_n out of reset.
  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = 2'b11;
    req_wr    = '0;
    exp_q.delete();
    hist      = '0;
    model_ptr = 0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_din   = '0;
    last_rsp  = '0;
    #1;
    chk("rst_req_ready",  32'(req_ready),     32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid),     32'd0);
    chk("rst_rsp_data",   32'(rsp_data),      32'd0);
    chk("rst_busy",       32'(busy),          32'd0);
    chk("rst_sram_we",    32'(sram_wr_rd_en), 32'd0);
    chk("rst_sram_addr",  32'(sram_addr),     32'd0);
    chk("rst_sram_din",   32'(sram_data_in),  32'd0);
    chk("rst_sram_rstn",  32'(sram_reset_n),  32'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_hold_ready", 32'(req_ready), 32'd0);
      chk("rst_hold_rsp",   32'(rsp_valid), 32'd0);
      chk("rst_hold_rstn",  32'(sram_reset_n), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_sram_rstn",  32'(sram_reset_n), 32'd0);
    chk("rel_req_ready",  32'(req_ready),    32'd0);
    @(posedge clk);
    #1;
    chk("up_sram_rstn",   32'(sram_reset_n), 32'd1);
    chk("up_req_ready",   32'(req_ready),    32'(2'b01));
    chk("up_busy",        32'(busy),         32'd0);
    req_valid = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]    v;
    logic [N-1:0]    wr;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    er;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] wr,
                              input logic [7:0] a1, input logic [7:0] a0,
                              input logic [7:0] d1, input logic [7:0] d0,
                              input logic [N-1:0] er);
    vec_t r;
    r.v  = v;
    r.wr = wr;
    r.a  = {a1, a0};
    r.d  = {d1, d0};
    r.er = er;
    return r;
  endfunction

  vec_t tbl [13];

  initial begin
    logic [N-1:0]    rv, rw;
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;

    // Starts with rr_ptr = 0 after the two preload writes below.
    tbl[0]  = mk(2'b01, 2'b01, 8'h00, 8'h10, 8'h00, 8'hA5, 2'b01);            // write 0x10 <- A5
    tbl[1]  = mk(2'b01, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 2'b01);            // read 0x10, lone requester
    tbl[2]  = mk(2'b11, 2'b00, 8'h02, 8'h01, 8'h00, 8'h00, PRIO ? 2'b01 : 2'b10);
    tbl[3]  = mk(2'b11, 2'b00, 8'h02, 8'h01, 8'h00, 8'h00, 2'b01);
    tbl[4]  = mk(2'b11, 2'b00, 8'h02, 8'h01, 8'h00, 8'h00, PRIO ? 2'b01 : 2'b10);
    tbl[5]  = mk(2'b11, 2'b00, 8'h02, 8'h01, 8'h00, 8'h00, 2'b01);
    tbl[6]  = mk(2'b10, 2'b10, 8'h3C, 8'h00, 8'h5A, 8'h00, 2'b10);            // write 0x3C <- 5A
    tbl[7]  = mk(2'b10, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 2'b10);            // read-after-write
    tbl[8]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);            // idle
    tbl[9]  = mk(2'b00, 2'b11, 8'h55, 8'h66, 8'hEE, 8'hFF, 2'b00);            // idle, wr set
    tbl[10] = mk(2'b10, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 2'b10);            // lone requester 1
    tbl[11] = mk(2'b01, 2'b01, 8'h00, 8'h02, 8'h00, 8'h77, 2'b01);            // write 0x02 <- 77
    tbl[12] = mk(2'b11, 2'b00, 8'h02, 8'h02, 8'h00, 8'h00, PRIO ? 2'b01 : 2'b10);

    #2;
    do_reset(3);

    // Preload 0x01 = 0x11 and 0x02 = 0x22 through the arbiter.
    apply(2'b01, 2'b01, {8'h00, 8'h01}, {8'h00, 8'h11}, 2'b01);
    apply(2'b10, 2'b10, {8'h02, 8'h00}, {8'h22, 8'h00}, 2'b10);

    for (int t = 0; t < 13; t++) begin
      apply(tbl[t].v, tbl[t].wr, tbl[t].a, tbl[t].d, tbl[t].er);
    end

    // Reset while a read of 0x10 is in flight: it must never respond, and the
    // SRAM keeps its contents.
    apply_rr(2'b01, 2'b00, {8'h00, 8'h10}, '0);
    do_reset(2);
    repeat (3) apply_rr(2'b00, 2'b00, '0, '0);
    apply_rr(2'b01, 2'b00, {8'h00, 8'h10}, '0);
    repeat (3) apply_rr(2'b00, 2'b00, '0, '0);

    // Requester 0 valid for 4 cycles while requester 1 stays valid.
    repeat (4) apply_rr(2'b11, 2'b00, {8'h02, 8'h01}, '0);
    repeat (2) apply_rr(2'b10, 2'b00, {8'h02, 8'h01}, '0);

    // Random traffic over a small address window (frequent address reuse).
    for (int i = 0; i < 8; i++) begin
      rv = (i % 2 == 0) ? 2'b01 : 2'b10;
      ra = {8'(8'h40 + i), 8'(8'h40 + i)};
      rd = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      apply_rr(rv, rv, ra, rd);
    end
    for (int i = 0; i < 40; i++) begin
      rv = 2'($urandom_range(0, 3));
      rw = 2'($urandom_range(0, 3));
      ra = {8'(8'h40 + $urandom_range(0, 7)), 8'(8'h40 + $urandom_range(0, 7))};
      rd = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      apply_rr(rv, rw, ra, rd);
    end

    // Drain and confirm nothing is left outstanding; rsp_data holds.
    repeat (4) apply_rr(2'b00, 2'b00, '0, '0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rsp_data_hold", 32'(rsp_data), 32'(last_rsp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port 256x8 synchronous SRAM (sram_if datapath) between N_REQ requesters.
- Round-robin grant: one accepted request per clock; write-first SRAM port.
- Issues write/read commands on registered SRAM port signals; returns read data to the owning requester with fixed latency.
- Sits between the requester-side blocks and the SRAM instance; sole driver of the SRAM command and reset inputs.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, SRAM address width.
- DATA_W, 8, SRAM data width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  request valid per requester.
- req_wr  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data.
- req_ready  out  N_REQ  one-hot grant; request k accepted when req_valid[k] && req_ready[k] at posedge.
- rsp_valid  out  N_REQ  one-cycle pulse, read data for requester k.
- rsp_data  out  DATA_W  read data; valid only while some rsp_valid bit is high.
- sram_reset_n  out  1  to SRAM reset_n.
- sram_wr_rd_en  out  1  to SRAM wr_rd_en.
- sram_addr  out  ADDR_W  to SRAM addr.
- sram_data_in  out  DATA_W  to SRAM data_in.
- sram_data_out  in  DATA_W  from SRAM data_out.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset values (async assert):
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 0.
  - sram_wr_rd_en = 0, sram_addr = 0, sram_data_in = 0.
  - sram_reset_n = 0; rr_ptr = 0.
- sram_reset_n: registered ~reset. Stays 0 for the first posedge after reset deasserts, then 1.
- req_ready is combinational from req_valid and rr_ptr.
  - Forced 0 while reset is high or sram_reset_n is 0.
  - Otherwise exactly one bit set: the first asserted req_valid at or after index rr_ptr, wrapping mod N_REQ.
  - All zeros if no req_valid.
- Acceptance at posedge E:
  - Register sram_wr_rd_en = req_wr[k], sram_addr = req_addr[k], sram_data_in = req_wdata[k].
  - rr_ptr <= (k+1) mod N_REQ.
- Idle cycle (no acceptance): sram_wr_rd_en <= 0. sram_addr and sram_data_in hold. The SRAM performs a harmless read.
- 2-stage read-tag pipeline:
  - Stage 1, set at E: rd_v1 = ~req_wr[k], id1 = k.
  - Stage 2, set at E+1: rd_v2 = rd_v1, id2 = id1.
  - At E+2: if rd_v2, rsp_data <= sram_data_out and rsp_valid <= one-hot(id2); else rsp_valid <= 0.
  - Latency: acceptance edge to rsp_valid high = 2 edges (visible in the cycle after E+2). Throughput: 1 request per cycle, back-to-back.
- Writes produce no response.
- Read-after-write to the same address in consecutive accepted cycles returns the new data (SRAM mem updated at E+1, read sampled at E+2).
- busy = rd_v1 | rd_v2 | (|rsp_valid).
- rsp_data holds its last value when no response is issued.
- Reset mid-operation:
  - All in-flight reads are discarded; no rsp_valid after reset.
  - rr_ptr returns to 0.
  - SRAM contents are not cleared.
- Single requester valid: granted every cycle regardless of rr_ptr.
- N_REQ requesters continuously valid: grants rotate 0,1,..,N_REQ-1,0.
- A requester whose req_valid drops before grant is never acknowledged; no latching of unaccepted requests.

Optional Feature:
- SRAM_ARB_PRIO_EN.
- Defined: requester 0 has strict priority. When req_valid[0] is set it is granted and rr_ptr is not updated; the other requesters round-robin among themselves when requester 0 is idle.
- Undefined: pure round-robin as above.

Test Plan:
- Reset then idle: hold reset 3 cycles, release. sram_reset_n goes 1 one cycle later; req_ready = 0 before that; all outputs 0 during reset.
- Single write/read: req0 write addr 0x10 data 0xA5, next cycle read 0x10. SRAM sees wr_rd_en 1 then 0. rsp_valid = 01 with rsp_data = 0xA5 exactly 2 edges after read acceptance.
- Contention: req0 and req1 both continuously valid, reading preloaded addrs 0x01 = 0x11 and 0x02 = 0x22.
  - Grants alternate 0,1,0,1.
  - rsp_valid alternates 01/10 with data 0x11/0x22 each cycle.
- Back-to-back RAW: req1 writes 0x3C <- 0x5A, then reads 0x3C in the next cycle. Returns 0x5A; writes never pulse rsp_valid.
- Reset mid-flight: accept a read to 0x10 (data 0xA5), assert reset the next cycle.
  - No rsp_valid ever appears.
  - After release, a read of 0x10 still returns 0xA5.
- SRAM_ARB_PRIO_EN defined: req0 valid 4 cycles, req1 valid throughout.
  - req1 is granted only after req0 drops.
  - Without the macro: grants alternate.
